// File: rtl/morra_cinese.sv
// Rock-paper-scissors match referee: validates and scores one manche per cycle,
// tracks wins and decides the match on a 2-point lead or when the manche limit is reached.
module morra_cinese #(
  parameter int MIN_MANCHES = 4
) (
  input  logic       clk,
  input  logic       INIZIA,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA,
  output logic [4:0] max_manches,
  output logic [4:0] manches_played,
  output logic [4:0] current_state,
  output logic [4:0] next_state,
  output logic       moves_are_valid,
  output logic       played_max,
  output logic       played_min,
  output logic [1:0] manche_winner,
  output logic [1:0] leading_player,
  output logic [1:0] tmp_game_winner,
  output logic [1:0] game_winner,
  output logic [1:0] last_p1_move,
  output logic [1:0] last_p2_move
);

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    PLAYING    = 2'd1,
    ENDED      = 2'd2
  } state_t;

  localparam logic [1:0] NONE     = 2'b00;
  localparam logic [1:0] ROCK     = 2'b01;
  localparam logic [1:0] PAPER    = 2'b10;
  localparam logic [1:0] SCISSORS = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [4:0] MIN_M = 5'(MIN_MANCHES);

  state_t     state_q, state_d;
  logic [4:0] max_q;
  logic [4:0] played_q, played_d;
  logic [4:0] p1_wins_q, p1_wins_d;
  logic [4:0] p2_wins_q, p2_wins_d;
  logic [1:0] last1_q, last1_d;
  logic [1:0] last2_q, last2_d;
  logic [1:0] manche_q, manche_d;
  logic [1:0] partita_q, partita_d;

  logic       valid;
  logic [1:0] winner;
  logic       lead_end;
  logic       max_end;

  function automatic logic [1:0] leader(input logic [4:0] a, input logic [4:0] b);
    if (a > b)      return RES_P1;
    else if (b > a) return RES_P2;
    else            return RES_DRAW;
  endfunction

  // The previous manche's winner may not repeat the move it won with.
  always_comb begin
    valid  = 1'b0;
    winner = RES_NONE;
    if (state_q == PLAYING) begin
      valid = (PRIMO != NONE) && (SECONDO != NONE) &&
              !((last1_q != NONE) && (PRIMO == last1_q)) &&
              !((last2_q != NONE) && (SECONDO == last2_q));
    end
    if (valid) begin
      if (PRIMO == SECONDO) begin
        winner = RES_DRAW;
      end else if ((PRIMO == ROCK     && SECONDO == SCISSORS) ||
                   (PRIMO == SCISSORS && SECONDO == PAPER)    ||
                   (PRIMO == PAPER    && SECONDO == ROCK)) begin
        winner = RES_P1;
      end else begin
        winner = RES_P2;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    played_d  = played_q;
    p1_wins_d = p1_wins_q;
    p2_wins_d = p2_wins_q;
    last1_d   = last1_q;
    last2_d   = last2_q;
    manche_d  = RES_NONE;
    partita_d = partita_q;
    lead_end  = 1'b0;
    max_end   = 1'b0;

    case (state_q)
      PLAYING: begin
        if (valid) begin
          manche_d = winner;
          played_d = played_q + 5'd1;
          case (winner)
            RES_P1: begin
              p1_wins_d = p1_wins_q + 5'd1;
              last1_d   = PRIMO;
              last2_d   = NONE;
            end
            RES_P2: begin
              p2_wins_d = p2_wins_q + 5'd1;
              last1_d   = NONE;
              last2_d   = SECONDO;
            end
            default: begin
              last1_d = NONE;
              last2_d = NONE;
            end
          endcase
          // Match end is judged on the counts including this manche.
          lead_end = (played_d >= MIN_M) &&
                     ((p1_wins_d >= p2_wins_d + 5'd2) || (p2_wins_d >= p1_wins_d + 5'd2));
          max_end  = (played_d == max_q);
          if (lead_end || max_end) begin
            partita_d = leader(p1_wins_d, p2_wins_d);
            state_d   = ENDED;
          end
        end
      end
      ENDED: begin
        state_d = ENDED;
      end
      default: begin
        state_d   = WAIT_START;
        partita_d = RES_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (INIZIA) begin
      state_q   <= PLAYING;
      max_q     <= {1'b0, PRIMO, SECONDO} + MIN_M;
      played_q  <= 5'd0;
      p1_wins_q <= 5'd0;
      p2_wins_q <= 5'd0;
      last1_q   <= NONE;
      last2_q   <= NONE;
      manche_q  <= RES_NONE;
      partita_q <= RES_NONE;
    end else begin
      state_q   <= state_d;
      played_q  <= played_d;
      p1_wins_q <= p1_wins_d;
      p2_wins_q <= p2_wins_d;
      last1_q   <= last1_d;
      last2_q   <= last2_d;
      manche_q  <= manche_d;
      partita_q <= partita_d;
    end
  end

  assign MANCHE          = manche_q;
  assign PARTITA         = partita_q;
  assign game_winner     = partita_q;
  assign max_manches     = max_q;
  assign manches_played  = played_q;
  assign current_state   = {3'b000, state_q};
  assign next_state      = INIZIA ? {3'b000, PLAYING} : {3'b000, state_d};
  assign moves_are_valid = valid;
  assign played_max      = (played_q == max_q);
  assign played_min      = (played_q >= MIN_M);
  assign manche_winner   = winner;
  assign leading_player  = leader(p1_wins_q, p2_wins_q);
  assign tmp_game_winner = INIZIA ? RES_NONE : partita_d;
  assign last_p1_move    = last1_q;
  assign last_p2_move    = last2_q;

endmodule

// File: tb/tb_morra_cinese.sv
// Self-checking bench for morra_cinese: directed match scenarios plus randomized
// matches, all compared against a rule-level reference model of the referee.
module tb_morra_cinese;

  logic       clk = 1'b0;
  logic       INIZIA = 1'b0;
  logic [1:0] PRIMO = 2'b00;
  logic [1:0] SECONDO = 2'b00;
  logic [1:0] MANCHE, PARTITA;
  logic [4:0] max_manches, manches_played, current_state, next_state;
  logic       moves_are_valid, played_max, played_min;
  logic [1:0] manche_winner, leading_player, tmp_game_winner, game_winner;
  logic [1:0] last_p1_move, last_p2_move;

  int checks = 0;
  int passes = 0;

  // Reference model: phase -1 unknown, 0 waiting, 1 playing, 2 ended.
  int mPhase = -1;
  int mMax, mPlayed, mP1, mP2, mL1, mL2, mManche, mPartita;

  always #5 clk = ~clk;

  morra_cinese #(.MIN_MANCHES(4)) dut (
    .clk(clk), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
    .MANCHE(MANCHE), .PARTITA(PARTITA),
    .max_manches(max_manches), .manches_played(manches_played),
    .current_state(current_state), .next_state(next_state),
    .moves_are_valid(moves_are_valid), .played_max(played_max), .played_min(played_min),
    .manche_winner(manche_winner), .leading_player(leading_player),
    .tmp_game_winner(tmp_game_winner), .game_winner(game_winner),
    .last_p1_move(last_p1_move), .last_p2_move(last_p2_move)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  function automatic bit modelValid(input int p1, input int p2);
    return (mPhase == 1) && (p1 != 0) && (p2 != 0) &&
           !(mL1 != 0 && p1 == mL1) && !(mL2 != 0 && p2 == mL2);
  endfunction

  function automatic int modelLeader(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  // One cycle: drive at negedge, check validity before the edge, outputs after it.
  task automatic applyStimulus(input bit init, input int p1, input int p2);
    bit v;
    int diff;
    @(negedge clk);
    INIZIA  = init;
    PRIMO   = 2'(p1);
    SECONDO = 2'(p2);
    #1;
    v = modelValid(p1, p2);
    if (mPhase >= 0) checkOutput("valid", int'(moves_are_valid), int'(v));
    if (init) begin
      mMax = p1 * 4 + p2 + 4;
      mPlayed = 0; mP1 = 0; mP2 = 0; mL1 = 0; mL2 = 0;
      mManche = 0; mPartita = 0; mPhase = 1;
    end else if (mPhase == 1 && v) begin
      mPlayed++;
      if (p1 == p2) begin
        mManche = 3; mL1 = 0; mL2 = 0;
      end else if ((p1 - p2 + 3) % 3 == 1) begin
        mManche = 1; mP1++; mL1 = p1; mL2 = 0;
      end else begin
        mManche = 2; mP2++; mL1 = 0; mL2 = p2;
      end
      diff = mP1 - mP2;
      if ((mPlayed >= 4 && (diff >= 2 || diff <= -2)) || mPlayed == mMax) begin
        mPartita = modelLeader(mP1, mP2);
        mPhase = 2;
      end
    end else begin
      mManche = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("MANCHE", int'(MANCHE), mManche);
    checkOutput("PARTITA", int'(PARTITA), mPartita);
    checkOutput("game_winner", int'(game_winner), mPartita);
    checkOutput("manches_played", int'(manches_played), mPlayed);
    checkOutput("max_manches", int'(max_manches), mMax);
    checkOutput("state", int'(current_state), mPhase);
    checkOutput("last_p1", int'(last_p1_move), mL1);
    checkOutput("last_p2", int'(last_p2_move), mL2);
    checkOutput("leading", int'(leading_player), modelLeader(mP1, mP2));
    checkOutput("played_min", int'(played_min), int'(mPlayed >= 4));
    checkOutput("played_max", int'(played_max), int'(mPlayed == mMax));
  endtask

  int mixed[7][2] = '{'{0,0}, '{2,1}, '{3,1}, '{0,2}, '{1,1}, '{1,1}, '{2,1}};
  int lead[4][2]  = '{'{1,2}, '{3,1}, '{2,3}, '{3,2}};

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);

    applyStimulus(1, 2, 1);
    checkOutput("plan_max13", int'(max_manches), 13);
    checkOutput("plan_start_state", int'(current_state), 1);
    foreach (mixed[i]) applyStimulus(0, mixed[i][0], mixed[i][1]);

    applyStimulus(1, 0, 1);
    checkOutput("plan_max5", int'(max_manches), 5);
    foreach (lead[i]) applyStimulus(0, lead[i][0], lead[i][1]);
    checkOutput("plan_lead_end", int'(PARTITA), 2);
    applyStimulus(0, 1, 3);
    checkOutput("plan_ended_manche", int'(MANCHE), 0);
    checkOutput("plan_ended_hold", int'(PARTITA), 2);

    applyStimulus(1, 3, 3);
    applyStimulus(0, 2, 1);
    applyStimulus(0, 2, 3);
    checkOutput("plan_repeat_block", int'(MANCHE), 0);
    checkOutput("plan_repeat_count", int'(manches_played), 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    checkOutput("plan_draw_repeat", int'(MANCHE), 3);

    applyStimulus(1, 0, 0);
    repeat (4) applyStimulus(0, 1, 1);
    checkOutput("plan_max_draw", int'(PARTITA), 3);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 2, 1);
    applyStimulus(0, 1, 3);
    applyStimulus(0, 3, 1);
    applyStimulus(0, 3, 2);
    checkOutput("plan_3_1", int'(PARTITA), 1);

    applyStimulus(1, 1, 1);
    applyStimulus(0, 2, 1);
    applyStimulus(0, 1, 3);
    applyStimulus(1, 3, 0);
    checkOutput("plan_restart_played", int'(manches_played), 0);
    checkOutput("plan_restart_max", int'(max_manches), 16);

    for (int m = 0; m < 30; m++) begin
      applyStimulus(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 40) == 0)
          applyStimulus(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        else
          applyStimulus(0,
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
